// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin sharing of the data memory between core (port 0) and debug/loader (port 1)
module dmem_arbiter #(
    parameter int AW = 32,
    parameter int DW = 32,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          p0_req,
    input  logic          p0_we,
    input  logic [2:0]    p0_fn3,
    input  logic [AW-1:0] p0_addr,
    input  logic [DW-1:0] p0_wdata,
    input  logic          p1_req,
    input  logic          p1_we,
    input  logic [2:0]    p1_fn3,
    input  logic [AW-1:0] p1_addr,
    input  logic [DW-1:0] p1_wdata,
    output logic          p0_gnt,
    output logic          p1_gnt,
    output logic          p0_stall,
    output logic          p0_rvalid,
    output logic          p1_rvalid,
    output logic [DW-1:0] p0_rdata,
    output logic [DW-1:0] p1_rdata,
    output logic          p0_err,
    output logic          p1_err,
    output logic          mem_read,
    output logic          mem_write,
    output logic [2:0]    mem_fn3,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic [CW-1:0] p0_conflicts,
    output logic [CW-1:0] p1_conflicts
);
    logic last, rd_pend, rd_id;
    logic bad0, bad1, v0, v1, win0, win1, fwd, we_sel;

    function automatic logic misal(input logic [2:0] f, input logic [1:0] a);
        return (f == 3'b011) | (f[2:1] == 2'b11) | ((f[1:0] == 2'b01) & a[0]) | ((f == 3'b010) & (a != 2'b00));
    endfunction

    // alignment check, round-robin pick and memory-side muxing; everything quiet while in reset
    always_comb begin
        bad0 = reset_n & p0_req & misal(p0_fn3, p0_addr[1:0]);
        bad1 = reset_n & p1_req & misal(p1_fn3, p1_addr[1:0]);
        v0 = reset_n & p0_req & ~bad0;
        v1 = reset_n & p1_req & ~bad1;
        win0 = v0 & (~v1 | last);
        win1 = v1 & ~win0;
        fwd = win0 | win1;
        we_sel = win1 ? p1_we : p0_we;
        p0_gnt = bad0 | win0;
        p1_gnt = bad1 | win1;
        p0_err = bad0;
        p1_err = bad1;
        p0_stall = reset_n & p0_req & ~p0_gnt;
        mem_read = fwd & ~we_sel;
        mem_write = fwd & we_sel;
        mem_fn3 = win1 ? p1_fn3 : win0 ? p0_fn3 : 3'b000;
        mem_addr = win1 ? p1_addr : win0 ? p0_addr : '0;
        mem_wdata = win1 ? p1_wdata : win0 ? p0_wdata : '0;
        p0_rvalid = rd_pend & ~rd_id;
        p1_rvalid = rd_pend & rd_id;
        p0_rdata = p0_rvalid ? mem_rdata : '0;
        p1_rdata = p1_rvalid ? mem_rdata : '0;
    end

    // round-robin pointer, load-return tag and saturating contention counters
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last <= 1'b1;
            rd_pend <= 1'b0;
            rd_id <= 1'b0;
            p0_conflicts <= '0;
            p1_conflicts <= '0;
        end else begin
            if (fwd) last <= win1;
            rd_pend <= mem_read;
            rd_id <= win1;
            if (v0 & win1 & ~&p0_conflicts) p0_conflicts <= p0_conflicts + 1'b1;
            if (v1 & win0 & ~&p1_conflicts) p1_conflicts <= p1_conflicts + 1'b1;
        end
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed checks of grant, return, alignment, reset and counter saturation
module tb_dmem_arbiter;
    logic        clk = 1'b0;
    logic        reset_n;
    logic        p0_req, p0_we, p1_req, p1_we;
    logic [2:0]  p0_fn3, p1_fn3;
    logic [31:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
    logic        p0_gnt, p1_gnt, p0_stall, p0_rvalid, p1_rvalid, p0_err, p1_err;
    logic [31:0] p0_rdata, p1_rdata;
    logic        mem_read, mem_write;
    logic [2:0]  mem_fn3;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  p0_conflicts, p1_conflicts;
    logic        st_valid;
    logic [31:0] st_addr, st_data;
    int          passed = 0;
    int          total = 0;

    dmem_arbiter #(.AW(32), .DW(32), .CW(4)) dut (
        .clk(clk), .reset_n(reset_n),
        .p0_req(p0_req), .p0_we(p0_we), .p0_fn3(p0_fn3), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p1_req(p1_req), .p1_we(p1_we), .p1_fn3(p1_fn3), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p0_gnt(p0_gnt), .p1_gnt(p1_gnt), .p0_stall(p0_stall),
        .p0_rvalid(p0_rvalid), .p1_rvalid(p1_rvalid), .p0_rdata(p0_rdata), .p1_rdata(p1_rdata),
        .p0_err(p0_err), .p1_err(p1_err),
        .mem_read(mem_read), .mem_write(mem_write), .mem_fn3(mem_fn3), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .p0_conflicts(p0_conflicts), .p1_conflicts(p1_conflicts)
    );

    always #5 clk = ~clk;

    // memory model: one remembered store, otherwise a word derived from the address
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            st_valid <= 1'b0;
            st_addr <= '0;
            st_data <= '0;
            mem_rdata <= '0;
        end else begin
            if (mem_write) begin
                st_valid <= 1'b1;
                st_addr <= mem_addr;
                st_data <= mem_wdata;
            end
            mem_rdata <= mem_read ? ((st_valid && mem_addr == st_addr) ? st_data : (32'hA500_0000 | mem_addr)) : 32'h0;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic nxt;
        @(posedge clk);
        #1;
    endtask

    task automatic drv0(input logic r, input logic w, input logic [2:0] f, input logic [31:0] a, input logic [31:0] d);
        p0_req = r; p0_we = w; p0_fn3 = f; p0_addr = a; p0_wdata = d;
    endtask

    task automatic drv1(input logic r, input logic w, input logic [2:0] f, input logic [31:0] a, input logic [31:0] d);
        p1_req = r; p1_we = w; p1_fn3 = f; p1_addr = a; p1_wdata = d;
    endtask

    initial begin
        reset_n = 1'b0;
        drv0(1, 0, 3'b010, 32'h10, 0);
        drv1(1, 0, 3'b010, 32'h40, 0);
        #4;
        chk("rst_p0_gnt", p0_gnt, 0);
        chk("rst_p1_gnt", p1_gnt, 0);
        chk("rst_mem_read", mem_read, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_stall", p0_stall, 0);
        chk("rst_rvalid", {p0_rvalid, p1_rvalid}, 0);
        chk("rst_conf", {p0_conflicts, p1_conflicts}, 0);
        nxt;
        nxt;
        reset_n = 1'b1;
        drv0(1, 0, 3'b010, 32'h10, 0);
        drv1(0, 0, 3'b000, 0, 0);
        #3;
        chk("lw_p0_gnt", p0_gnt, 1);
        chk("lw_p1_gnt", p1_gnt, 0);
        chk("lw_mem_read", mem_read, 1);
        chk("lw_mem_addr", mem_addr, 32'h10);
        chk("lw_stall", p0_stall, 0);
        nxt;
        drv0(0, 0, 3'b000, 0, 0);
        drv1(1, 1, 3'b010, 32'h20, 32'hDEADBEEF);
        #3;
        chk("lw_p0_rvalid", p0_rvalid, 1);
        chk("lw_p0_rdata", p0_rdata, 32'hA500_0010);
        chk("lw_p1_rvalid", p1_rvalid, 0);
        chk("sw_p1_gnt", p1_gnt, 1);
        chk("sw_mem_write", mem_write, 1);
        chk("sw_mem_read", mem_read, 0);
        chk("sw_mem_wdata", mem_wdata, 32'hDEADBEEF);
        nxt;
        drv1(0, 0, 3'b000, 0, 0);
        drv0(1, 0, 3'b010, 32'h20, 0);
        #3;
        chk("sw_no_rvalid", p1_rvalid, 0);
        chk("ld20_gnt", p0_gnt, 1);
        chk("ld20_mem_read", mem_read, 1);
        nxt;
        drv0(1, 0, 3'b001, 32'h21, 0);
        drv1(1, 0, 3'b010, 32'h40, 0);
        #3;
        chk("ld20_rdata", p0_rdata, 32'hDEADBEEF);
        chk("mis_p0_gnt", p0_gnt, 1);
        chk("mis_p0_err", p0_err, 1);
        chk("mis_p1_gnt", p1_gnt, 1);
        chk("mis_p1_err", p1_err, 0);
        chk("mis_mem_addr", mem_addr, 32'h40);
        chk("mis_mem_read", mem_read, 1);
        nxt;
        drv0(0, 0, 3'b000, 0, 0);
        drv1(0, 0, 3'b000, 0, 0);
        #3;
        chk("mis_p1_rvalid", p1_rvalid, 1);
        chk("mis_p1_rdata", p1_rdata, 32'hA500_0040);
        chk("mis_p0_rvalid", p0_rvalid, 0);
        chk("mis_err_clear", p0_err, 0);
        for (int i = 0; i < 6; i++) begin
            nxt;
            drv0(1, 0, 3'b010, 32'h10, 0);
            drv1(1, 0, 3'b010, 32'h40, 0);
            #3;
            chk($sformatf("rr_p0_gnt_%0d", i), p0_gnt, (i % 2 == 0));
            chk($sformatf("rr_p1_gnt_%0d", i), p1_gnt, (i % 2 == 1));
            chk($sformatf("rr_stall_%0d", i), p0_stall, (i % 2 == 1));
            if (i > 0) chk($sformatf("rr_p0_rvalid_%0d", i), p0_rvalid, (i % 2 == 0) ? 1'b0 : 1'b1);
        end
        nxt;
        drv0(0, 0, 3'b000, 0, 0);
        drv1(0, 0, 3'b000, 0, 0);
        #3;
        chk("rr_p0_conf", p0_conflicts, 3);
        chk("rr_p1_conf", p1_conflicts, 3);
        chk("rr_p1_rvalid", p1_rvalid, 1);
        chk("rr_p1_rdata", p1_rdata, 32'hA500_0040);
        nxt;
        drv1(1, 0, 3'b010, 32'h40, 0);
        #3;
        chk("rl_p1_gnt", p1_gnt, 1);
        #2;
        reset_n = 1'b0;
        drv0(1, 0, 3'b010, 32'h10, 0);
        #1;
        chk("rl_gnt_low", {p0_gnt, p1_gnt}, 0);
        chk("rl_mem_read", mem_read, 0);
        chk("rl_mem_addr", mem_addr, 0);
        chk("rl_stall", p0_stall, 0);
        chk("rl_conf", {p0_conflicts, p1_conflicts}, 0);
        nxt;
        #3;
        chk("rl_p1_rvalid", p1_rvalid, 0);
        chk("rl_p1_rdata", p1_rdata, 0);
        nxt;
        reset_n = 1'b1;
        #3;
        chk("rl_tie_p0", p0_gnt, 1);
        chk("rl_tie_p1", p1_gnt, 0);
        chk("rl_no_rvalid", p1_rvalid, 0);
        for (int i = 1; i < 28; i++) nxt;
        nxt;
        #3;
        chk("sat_p0_14", p0_conflicts, 14);
        chk("sat_p1_14", p1_conflicts, 14);
        for (int i = 0; i < 5; i++) nxt;
        nxt;
        #3;
        chk("sat_p0_15", p0_conflicts, 15);
        chk("sat_p1_15", p1_conflicts, 15);
        drv0(0, 0, 3'b000, 0, 0);
        drv1(0, 0, 3'b000, 0, 0);
        nxt;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
